pipelined_ripple_adder: RTL
===========================

Name: pipelined_ripple_adder

Overview:
- Parametrised, pipelined successor to the single-cycle 32-bit ripple adder.
- Splits a WIDTH-bit add/subtract into STAGES ripple chunks, one register stage per chunk, so timing closes at higher clock rates.
- Adds carry-in, subtract mode, unsigned carry-out and valid/ready flow control with per-stage bubble collapse.
- Sits between the operand-select logic and the ALU result mux.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); CHUNK = WIDTH/STAGES bits per stage.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  stage 0 can accept.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in, add mode only.
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- sum  output  WIDTH  result.
- cout  output  1  unsigned carry-out; in subtract mode, 1 = no borrow.
- overflow  output  1  two's-complement overflow.

Behaviour:
- Arithmetic (modulo 2^WIDTH):
  - sub=0: sum = a + b + cin.
  - sub=1: sum = a + ~b + 1; cin is ignored.
  - cout = carry out of bit WIDTH-1.
  - overflow = carry into MSB XOR carry out of MSB, equivalent to (a_msb == b_eff_msb) && (sum_msb != a_msb).
- Stage k (0..STAGES-1):
  - Ripples bits [k*CHUNK +: CHUNK] using the carry registered by stage k-1. Stage 0 uses the effective carry-in.
  - Registers its chunk result, its carry-out, and all lower result chunks already computed.
  - Registers the unprocessed upper operand bits, with b already inverted when sub=1.
  - The last stage also registers the MSB carry-in for overflow.
- Per-stage handshake:
  - valid_k register per stage.
  - ready_k = !valid_k || ready_{k+1}, with ready_STAGES = out_ready; this chain is combinational.
  - in_ready = ready_0.
  - Stage k loads when ready_k is high; valid_k <= valid_{k-1} (in_valid for k=0).
  - Data registers load only when ready_k && incoming valid, otherwise they hold.
- Latency: exactly STAGES cycles from input handshake to out_valid with no stalls. Throughput is 1 result per cycle.
- Backpressure:
  - While out_ready=0 and out_valid=1, sum, cout and overflow stay stable.
  - Upstream bubbles are squeezed out.
  - The accepted transaction count equals the delivered count, and order is preserved.
- in_ready may be high while out_ready=0 if an internal bubble exists.
- Simultaneous accept at input and output in the same cycle is legal when full; the pipeline stays full.
- Reset (asynchronous, any time including mid-operation):
  - All valid_k = 0, so out_valid = 0 and in-flight results are discarded.
  - sum, cout, overflow and all data registers = 0.
  - in_ready = 1 once reset is applied.
- STAGES=1: degenerates to a single registered full-width ripple adder, latency 1.
- Outputs are driven only from registers; there is no combinational path from a/b to sum.

Decomposition:
- Shared package alu_pkg:
  - ALU_WIDTH = 32.
  - ADDER_STAGES default 4.
  - Op encoding constants OP_ADD = 1'b0 and OP_SUB = 1'b1.
- Sub-module adder_chunk:
  - Combinational CHUNK-bit ripple built from the existing full_adder.
  - Ports: a, b, cin, sum, cout, msb_cin.
  - Instantiated once per stage inside a generate loop.

Test Plan:
- Reset, then add 32'h0000_0005 + 32'h0000_0003, cin=0, out_ready=1 -> after 4 cycles out_valid=1, sum=32'h0000_0008, cout=0, overflow=0.
- Signed/unsigned edges:
  - 32'h7FFF_FFFF + 1 -> sum=32'h8000_0000, overflow=1, cout=0.
  - 32'hFFFF_FFFF + 1 -> sum=0, cout=1, overflow=0.
  - Subtract 32'h8000_0000 - 1 -> sum=32'h7FFF_FFFF, overflow=1, cout=1.
- Carry propagation across chunk boundaries: 32'h00FF_FFFF + 32'h0000_0001 with cin=1 -> sum=32'h0100_0001, cout=0.
- Stream 8 back-to-back random ops with out_ready toggled pseudo-randomly -> results bit-exact against a reference model, in order, no loss or duplication, outputs stable during stalls.
- Reset mid-stream with 3 ops in flight -> out_valid=0 and sum=0 immediately after rst rises; after release, a fresh 1+1 yields sum=2 after 4 cycles and no stale results appear.
- Sweep parameters (WIDTH,STAGES) = (32,1), (16,2), (64,8) -> latency equals STAGES and random add/sub results match the model.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths, adder pipeline depth and op encodings
package alu_pkg;

   localparam int   ALU_WIDTH    = 32;
   localparam int   ADDER_STAGES = 4;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/pipelined_ripple_adder_if.sv
// rtl/pipelined_ripple_adder_if.sv - operand/result handshake bundle for the pipelined adder
interface pipelined_ripple_adder_if
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, overflow
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, overflow
   );

endinterface

// File: rtl/adder_chunk.sv
// rtl/adder_chunk.sv - combinational CHUNK-bit ripple of full_adder cells
module adder_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             msb_cin
);

   // Carries are per-bit block locals so each link of the chain is its own net.
   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      logic ci;
      logic co;
      if (i == 0) begin : g_lsb
         assign ci = cin;
      end else begin : g_up
         assign ci = g_bit[i-1].co;
      end
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (ci),
         .sum  (sum[i]),
         .cout (co)
      );
   end

   assign cout    = g_bit[CHUNK-1].co;
   assign msb_cin = g_bit[CHUNK-1].ci;

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_ripple_adder.sv
// rtl/pipelined_ripple_adder.sv - WIDTH-bit add/sub split into STAGES registered ripple chunks
module pipelined_ripple_adder
   import alu_pkg::*;
#(
   parameter int WIDTH  = ALU_WIDTH,
   parameter int STAGES = ADDER_STAGES
) (
   input  logic                     clk,
   input  logic                     rst,
   pipelined_ripple_adder_if.slave  bus
);

   localparam int CHUNK = WIDTH / STAGES;

   logic [STAGES-1:0] valid;
   logic [STAGES-1:0] rdy;
   logic [STAGES-1:0] carry_s;
   logic [WIDTH-1:0]  res_s [STAGES];
   logic [WIDTH-1:0]  a_s   [STAGES];
   logic [WIDTH-1:0]  b_s   [STAGES];
   logic              msbc_q;

   // A stage can load when it is empty or the stage after it is draining.
   always_comb begin : ready_chain
      logic r;
      r   = bus.out_ready;
      rdy = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         r      = !valid[k] || r;
         rdy[k] = r;
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] a_in, b_in, res_in, res_nx;
      logic [WIDTH-1:0] a_q, b_q, res_q;
      logic [CHUNK-1:0] ch_sum;
      logic             c_in, v_in, v_q, c_q, ch_cout, ch_msbc;

      if (k == 0) begin : g_first
         // Subtract folds into add: invert b once here and force the carry-in.
         assign a_in   = bus.a;
         assign b_in   = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
         assign c_in   = (bus.sub == OP_SUB) ? 1'b1 : bus.cin;
         assign res_in = '0;
         assign v_in   = bus.in_valid;
      end else begin : g_next
         assign a_in   = a_s[k-1];
         assign b_in   = b_s[k-1];
         assign c_in   = carry_s[k-1];
         assign res_in = res_s[k-1];
         assign v_in   = valid[k-1];
      end

      adder_chunk #(.CHUNK(CHUNK)) u_chunk (
         .a       (a_in[k*CHUNK +: CHUNK]),
         .b       (b_in[k*CHUNK +: CHUNK]),
         .cin     (c_in),
         .sum     (ch_sum),
         .cout    (ch_cout),
         .msb_cin (ch_msbc)
      );

      always_comb begin
         res_nx                     = res_in;
         res_nx[k*CHUNK +: CHUNK]   = ch_sum;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v_q   <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            c_q   <= 1'b0;
         end else begin
            if (rdy[k]) begin
               v_q <= v_in;
            end
            if (rdy[k] && v_in) begin
               a_q   <= a_in;
               b_q   <= b_in;
               res_q <= res_nx;
               c_q   <= ch_cout;
            end
         end
      end

      assign valid[k]   = v_q;
      assign carry_s[k] = c_q;
      assign res_s[k]   = res_q;
      assign a_s[k]     = a_q;
      assign b_s[k]     = b_q;

      if (k == STAGES - 1) begin : g_last
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               msbc_q <= 1'b0;
            end else if (rdy[k] && v_in) begin
               msbc_q <= ch_msbc;
            end
         end
      end else begin : g_mid
         logic unused_msbc;
         assign unused_msbc = ch_msbc;
      end
   end

   assign bus.in_ready  = rdy[0];
   assign bus.out_valid = valid[STAGES-1];
   assign bus.sum       = res_s[STAGES-1];
   assign bus.cout      = carry_s[STAGES-1];
   assign bus.overflow  = carry_s[STAGES-1] ^ msbc_q;

endmodule
